// File: rtl/odmb_link_pkg.sv
// Shared definitions for the DCFEB/ODMB 16-bit packet link: 8b10b octets, framing words, tx FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package odmb_link_pkg;

   // 8b10b octet codes
   localparam logic [7:0] K28_5    = 8'hBC;
   localparam logic [7:0] K27_7    = 8'hFB;
   localparam logic [7:0] K29_7    = 8'hFD;
   localparam logic [7:0] K23_7    = 8'hF7;
   localparam logic [7:0] K30_7    = 8'hFE;
   localparam logic [7:0] D5_6     = 8'hC5;
   localparam logic [7:0] D16_2    = 8'h50;
   localparam logic [7:0] PRMBL    = 8'h55;
   localparam logic [7:0] SOF_BYTE = 8'hD5;

   // Link words; byte [7:0] is serialised first
   localparam logic [15:0] IDLE1         = {D5_6, K28_5};     // first idle after EOP, flips disparity
   localparam logic [15:0] IDLE2         = {D16_2, K28_5};    // steady-state idle
   localparam logic [15:0] PREAMBLE1     = {PRMBL, K27_7};    // SOP
   localparam logic [15:0] PREAMBLE2     = {PRMBL, PRMBL};
   localparam logic [15:0] PREAMBLE3     = {PRMBL, PRMBL};
   localparam logic [15:0] PREAMBLE4     = {SOF_BYTE, PRMBL}; // SOF
   localparam logic [15:0] End_of_Packet = {K23_7, K29_7};
   localparam logic [15:0] ERR_WORD      = {K30_7, K30_7};

   typedef enum logic [3:0] {IDLE, PRE1, PRE2, PRE3, PRE4, DATA, CRC, ERR, EOP} tx_state_t;

endpackage

// File: rtl/tx_frame_gen_if.sv
// Payload stream into the transmit framer: valid/ready with an end-of-frame marker.
// Latency: none (wires only).
// Backpressure: a word moves on a clock edge where TX_VALID and TX_READY are both high.
interface tx_frame_gen_if;
   logic [15:0] TX_DATA;
   logic        TX_VALID;
   logic        TX_LAST;
   logic        TX_READY;

   modport master (output TX_DATA, output TX_VALID, output TX_LAST, input TX_READY);
   modport slave  (input TX_DATA, input TX_VALID, input TX_LAST, output TX_READY);
endinterface

// File: rtl/crc32_bgb.sv
// CRC-32 (poly 04C11DB7) over 16-bit link words, low byte first; low 16 bits form the link CRC word.
// Latency: crc reflects every word with calc=1 up to and including the previous edge.
// Backpressure: none; init and calc are sampled every clock.
module crc32_bgb (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        calc,
   input  logic [15:0] d,
   output logic [15:0] crc
);
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // Fold the word in bit by bit, bit 0 first, so byte [7:0] enters before byte [15:8]
   always_comb begin
      crc_d = crc_q;
      for (int i = 0; i < 16; i++) begin
         if (crc_d[31] ^ d[i]) crc_d = {crc_d[30:0], 1'b0} ^ POLY;
         else                  crc_d = {crc_d[30:0], 1'b0};
      end
   end

   // Running CRC register, preset to all ones at frame start
   always_ff @(posedge clk) begin
      if (rst | init)  crc_q <= '1;
      else if (calc)   crc_q <= crc_d;
   end

   assign crc = crc_q[15:0];
endmodule

// File: rtl/tx_frame_gen.sv
// Link transmit framer: preamble/SOF, payload, CRC, EOP and idles into the 8b10b encoder.
// Latency: payload word appears on TXDATA one clock after it is accepted; SOP one edge after TX_VALID seen in IDLE.
// Backpressure: TX_READY depends on state only; starved payload aborts the frame with ERR+EOP.
// Optional build macro TX_CRC_ERR_INJECT_EN adds INJ_CRC_ERR to corrupt bit 0 of the CRC word.
module tx_frame_gen
   import odmb_link_pkg::*;
#(
   parameter int MAX_COUNT = 812,
   parameter int IFG_WORDS = 4
) (
   input  logic          CLK,
   input  logic          RST,
`ifdef TX_CRC_ERR_INJECT_EN
   input  logic          INJ_CRC_ERR,
`endif
   tx_frame_gen_if.slave tx,
   output logic [15:0]   TXDATA,
   output logic [1:0]    TX_IS_K,
   output logic          BUSY,
   output logic          FRM_SENT,
   output logic          UNDERRUN,
   output logic          OVERLEN
);
   localparam logic [11:0] MAX_W = 12'(MAX_COUNT);
   localparam logic [7:0]  IFG_W = 8'(IFG_WORDS);

   tx_state_t   state_q;
   logic [15:0] txdata_q;
   logic [1:0]  txk_q;
   logic        frm_sent_q, underrun_q, overlen_q;
   logic [11:0] wcnt_q;
   logic [7:0]  ifg_q;
   logic        rst_ifg_ok_q;  // the gap is considered met until the first frame after reset
   logic        last_taken_q;  // no more payload for this frame
   logic        ovl_pend_q;    // frame closed by MAX_COUNT rather than TX_LAST
   logic        abort_q;       // frame ended with ERR, tail of the source frame must be dropped
   logic        flush_q;       // dropping source words up to and including TX_LAST

   logic        pay_rdy, accept, ifg_ok;
   logic [11:0] wcnt_d;
   logic [15:0] crc_out, crc_word;

   assign pay_rdy     = (state_q == PRE4) | ((state_q == DATA) & !last_taken_q);
   assign tx.TX_READY = pay_rdy | flush_q;
   assign accept      = pay_rdy & tx.TX_VALID;
   assign wcnt_d      = (wcnt_q == 12'hFFF) ? wcnt_q : wcnt_q + 12'd1;
   assign ifg_ok      = rst_ifg_ok_q | (ifg_q >= IFG_W);

`ifdef TX_CRC_ERR_INJECT_EN
   assign crc_word = crc_out ^ {15'd0, INJ_CRC_ERR};
`else
   assign crc_word = crc_out;
`endif

   crc32_bgb u_crc (
      .clk  (CLK),
      .rst  (RST),
      .init (state_q == PRE1),
      .calc (accept),
      .d    (tx.TX_DATA),
      .crc  (crc_out)
   );

   // Framing FSM; the wire word, K flags and status pulses load on the same edge as the state
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         txdata_q     <= IDLE2;
         txk_q        <= 2'b01;
         frm_sent_q   <= 1'b0;
         underrun_q   <= 1'b0;
         overlen_q    <= 1'b0;
         wcnt_q       <= '0;
         ifg_q        <= '0;
         rst_ifg_ok_q <= 1'b1;
         last_taken_q <= 1'b0;
         ovl_pend_q   <= 1'b0;
         abort_q      <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         frm_sent_q <= 1'b0;
         underrun_q <= 1'b0;
         overlen_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_q && tx.TX_VALID && tx.TX_LAST) flush_q <= 1'b0;
               if (tx.TX_VALID && ifg_ok && !flush_q) begin
                  state_q      <= PRE1;
                  txdata_q     <= PREAMBLE1;
                  txk_q        <= 2'b01;
                  rst_ifg_ok_q <= 1'b0;
                  wcnt_q       <= '0;
                  last_taken_q <= 1'b0;
                  ovl_pend_q   <= 1'b0;
                  abort_q      <= 1'b0;
               end else begin
                  txdata_q <= IDLE2;
                  txk_q    <= 2'b01;
                  if (ifg_q != 8'hFF) ifg_q <= ifg_q + 8'd1;
               end
            end
            PRE1: begin state_q <= PRE2; txdata_q <= PREAMBLE2; txk_q <= 2'b00; end
            PRE2: begin state_q <= PRE3; txdata_q <= PREAMBLE3; txk_q <= 2'b00; end
            PRE3: begin state_q <= PRE4; txdata_q <= PREAMBLE4; txk_q <= 2'b00; end
            PRE4, DATA: begin
               if (!pay_rdy) begin
                  // payload complete: CRC if closed by TX_LAST, otherwise abort the oversize frame
                  if (ovl_pend_q) begin
                     state_q   <= ERR;
                     txdata_q  <= ERR_WORD;
                     txk_q     <= 2'b11;
                     overlen_q <= 1'b1;
                     abort_q   <= 1'b1;
                  end else begin
                     state_q  <= CRC;
                     txdata_q <= crc_word;
                     txk_q    <= 2'b00;
                  end
               end else if (tx.TX_VALID) begin
                  state_q  <= DATA;
                  txdata_q <= tx.TX_DATA;
                  txk_q    <= 2'b00;
                  wcnt_q   <= wcnt_d;
                  if (tx.TX_LAST || (wcnt_d == MAX_W)) last_taken_q <= 1'b1;
                  if (!tx.TX_LAST && (wcnt_d == MAX_W)) ovl_pend_q <= 1'b1;
               end else begin
                  state_q    <= ERR;
                  txdata_q   <= ERR_WORD;
                  txk_q      <= 2'b11;
                  underrun_q <= 1'b1;
                  abort_q    <= 1'b1;
               end
            end
            CRC, ERR: begin
               state_q    <= EOP;
               txdata_q   <= End_of_Packet;
               txk_q      <= 2'b11;
               frm_sent_q <= 1'b1;
            end
            EOP: begin
               state_q  <= IDLE;
               txdata_q <= IDLE1;
               txk_q    <= 2'b01;
               ifg_q    <= 8'd1;
               flush_q  <= abort_q;
            end
            default: begin
               state_q  <= IDLE;
               txdata_q <= IDLE2;
               txk_q    <= 2'b01;
            end
         endcase
      end
   end

   assign TXDATA   = txdata_q;
   assign TX_IS_K  = txk_q;
   assign BUSY     = (state_q != IDLE);
   assign FRM_SENT = frm_sent_q;
   assign UNDERRUN = underrun_q;
   assign OVERLEN  = overlen_q;
endmodule

// File: tb/tb_tx_frame_gen.sv
// Directed bench for tx_frame_gen built with MAX_COUNT=8, IFG_WORDS=4.
// Per-cycle vectors: inputs driven after a rising edge, TX_READY checked before the next edge,
// wire word, K flags and {BUSY,FRM_SENT,UNDERRUN,OVERLEN} checked just after it.
module tb_tx_frame_gen;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] TXDATA;
   logic [1:0]  TX_IS_K;
   logic        BUSY, FRM_SENT, UNDERRUN, OVERLEN;
`ifdef TX_CRC_ERR_INJECT_EN
   logic        inj = 1'b0;
`endif

   int n_chk = 0;
   int n_err = 0;

   tx_frame_gen_if txi ();

   tx_frame_gen #(.MAX_COUNT(8), .IFG_WORDS(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
`ifdef TX_CRC_ERR_INJECT_EN
      .INJ_CRC_ERR (inj),
`endif
      .tx       (txi.slave),
      .TXDATA   (TXDATA),
      .TX_IS_K  (TX_IS_K),
      .BUSY     (BUSY),
      .FRM_SENT (FRM_SENT),
      .UNDERRUN (UNDERRUN),
      .OVERLEN  (OVERLEN)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, vld, lst;
      logic [15:0] d;
      logic        chk_rdy, rdy;
      logic [15:0] xd;
      logic [1:0]  xk;
      logic [3:0]  xf;   // {BUSY, FRM_SENT, UNDERRUN, OVERLEN}
   } vec_t;

   function automatic vec_t mv(input logic rst, input logic vld, input logic lst, input logic [15:0] d,
                               input logic chk_rdy, input logic rdy, input logic [15:0] xd,
                               input logic [1:0] xk, input logic [3:0] xf);
      vec_t v;
      v.rst = rst; v.vld = vld; v.lst = lst; v.d = d;
      v.chk_rdy = chk_rdy; v.rdy = rdy; v.xd = xd; v.xk = xk; v.xf = xf;
      return v;
   endfunction

   // Reference CRC: CRC-32 poly 04C11DB7, preset all ones, bit 0 of each word first, low half sent
   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [15:0] w);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 0; i < 16; i++) begin
         fb = c[31] ^ w[i];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C11DB7;
      end
      return c;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic vld, input logic lst, input logic [15:0] d,
                      input logic chk_rdy, input logic rdy, input logic [15:0] xd,
                      input logic [1:0] xk, input logic [3:0] xf, input string nm);
      RST = rst;
      txi.TX_VALID = vld;
      txi.TX_LAST  = lst;
      txi.TX_DATA  = d;
      #1;
      if (chk_rdy) check({nm, " ready"}, 32'(txi.TX_READY), 32'(rdy));
      @(posedge CLK);
      #1;
      check({nm, " txdata"}, 32'(TXDATA), 32'(xd));
      check({nm, " is_k"}, 32'(TX_IS_K), 32'(xk));
      check({nm, " flags"}, 32'({BUSY, FRM_SENT, UNDERRUN, OVERLEN}), 32'(xf));
   endtask

   initial begin
      vec_t        v[$];
      logic [15:0] crc3, crc_a, crc_b;
      logic [15:0] w;

      crc3  = 16'(crc_step(crc_step(crc_step(32'hFFFFFFFF, 16'h1111), 16'h2222), 16'h3333));
      crc_a = 16'(crc_step(32'hFFFFFFFF, 16'hAAAA));
      crc_b = 16'(crc_step(32'hFFFFFFFF, 16'hBBBB));

      // reset held three cycles with no traffic
      for (int i = 0; i < 3; i++) v.push_back(mv(1, 0, 0, 16'h0, i > 0, 0, 16'h50BC, 2'b01, 4'b0000));
      // 3-word frame straight out of reset
      v.push_back(mv(0, 1, 0, 16'h1111, 1, 0, 16'h55FB, 2'b01, 4'b1000));
      v.push_back(mv(0, 1, 0, 16'h1111, 1, 0, 16'h5555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 0, 16'h1111, 1, 0, 16'h5555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 0, 16'h1111, 1, 0, 16'hD555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 0, 16'h1111, 1, 1, 16'h1111, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 0, 16'h2222, 1, 1, 16'h2222, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'h3333, 1, 1, 16'h3333, 2'b00, 4'b1000));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, crc3, 2'b00, 4'b1000));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, 16'hF7FD, 2'b11, 4'b1100));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, 16'hC5BC, 2'b01, 4'b0000));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000));
      // back-to-back 1-word frames with TX_VALID held: exactly 4 idles between EOP and SOP
      v.push_back(mv(1, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000));
      v.push_back(mv(0, 1, 1, 16'hAAAA, 1, 0, 16'h55FB, 2'b01, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hAAAA, 1, 0, 16'h5555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hAAAA, 1, 0, 16'h5555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hAAAA, 1, 0, 16'hD555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hAAAA, 1, 1, 16'hAAAA, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, crc_a, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'hF7FD, 2'b11, 4'b1100));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'hC5BC, 2'b01, 4'b0000));
      for (int i = 0; i < 3; i++) v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'h50BC, 2'b01, 4'b0000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'h55FB, 2'b01, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'h5555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'h5555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 0, 16'hD555, 2'b00, 4'b1000));
      v.push_back(mv(0, 1, 1, 16'hBBBB, 1, 1, 16'hBBBB, 2'b00, 4'b1000));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, crc_b, 2'b00, 4'b1000));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, 16'hF7FD, 2'b11, 4'b1100));
      v.push_back(mv(0, 0, 0, 16'h0, 1, 0, 16'hC5BC, 2'b01, 4'b0000));

      txi.TX_VALID = 1'b0;
      txi.TX_LAST  = 1'b0;
      txi.TX_DATA  = 16'h0;
      @(posedge CLK);
      #1;

      for (int i = 0; i < v.size(); i++)
         cyc(v[i].rst, v[i].vld, v[i].lst, v[i].d, v[i].chk_rdy, v[i].rdy, v[i].xd, v[i].xk, v[i].xf,
             $sformatf("vec%0d", i));

      // underrun after word 2 of 5, tail flushed, then mid-frame reset
      cyc(1, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000, "und_rst");
      cyc(0, 1, 0, 16'h0101, 1, 0, 16'h55FB, 2'b01, 4'b1000, "und_sop");
      cyc(0, 1, 0, 16'h0101, 1, 0, 16'h5555, 2'b00, 4'b1000, "und_pre2");
      cyc(0, 1, 0, 16'h0101, 1, 0, 16'h5555, 2'b00, 4'b1000, "und_pre3");
      cyc(0, 1, 0, 16'h0101, 1, 0, 16'hD555, 2'b00, 4'b1000, "und_sof");
      cyc(0, 1, 0, 16'h0101, 1, 1, 16'h0101, 2'b00, 4'b1000, "und_w1");
      cyc(0, 1, 0, 16'h0202, 1, 1, 16'h0202, 2'b00, 4'b1000, "und_w2");
      cyc(0, 0, 0, 16'h0, 1, 1, 16'hFEFE, 2'b11, 4'b1010, "und_err");
      cyc(0, 1, 0, 16'h0303, 1, 0, 16'hF7FD, 2'b11, 4'b1100, "und_eop");
      cyc(0, 1, 0, 16'h0303, 1, 0, 16'hC5BC, 2'b01, 4'b0000, "und_idle1");
      cyc(0, 1, 0, 16'h0303, 1, 1, 16'h50BC, 2'b01, 4'b0000, "und_drop3");
      cyc(0, 1, 0, 16'h0404, 1, 1, 16'h50BC, 2'b01, 4'b0000, "und_drop4");
      cyc(0, 1, 1, 16'h0505, 1, 1, 16'h50BC, 2'b01, 4'b0000, "und_drop5");
      cyc(0, 1, 1, 16'h0A0A, 1, 0, 16'h55FB, 2'b01, 4'b1000, "und_next_sop");
      cyc(0, 1, 1, 16'h0A0A, 1, 0, 16'h5555, 2'b00, 4'b1000, "mid_pre2");
      cyc(1, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000, "mid_rst");
      cyc(0, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000, "mid_after");

      // 10-word frame against MAX_COUNT=8
      cyc(1, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000, "ovl_rst");
      cyc(0, 1, 0, 16'h00A1, 1, 0, 16'h55FB, 2'b01, 4'b1000, "ovl_sop");
      cyc(0, 1, 0, 16'h00A1, 1, 0, 16'h5555, 2'b00, 4'b1000, "ovl_pre2");
      cyc(0, 1, 0, 16'h00A1, 1, 0, 16'h5555, 2'b00, 4'b1000, "ovl_pre3");
      cyc(0, 1, 0, 16'h00A1, 1, 0, 16'hD555, 2'b00, 4'b1000, "ovl_sof");
      for (int k = 1; k <= 8; k++) begin
         w = 16'(16'h00A0 + k);
         cyc(0, 1, 0, w, 1, 1, w, 2'b00, 4'b1000, $sformatf("ovl_w%0d", k));
      end
      cyc(0, 1, 0, 16'h00A9, 1, 0, 16'hFEFE, 2'b11, 4'b1001, "ovl_err");
      cyc(0, 1, 0, 16'h00A9, 1, 0, 16'hF7FD, 2'b11, 4'b1100, "ovl_eop");
      cyc(0, 1, 0, 16'h00A9, 1, 0, 16'hC5BC, 2'b01, 4'b0000, "ovl_idle1");
      cyc(0, 1, 0, 16'h00A9, 1, 1, 16'h50BC, 2'b01, 4'b0000, "ovl_drop9");
      cyc(0, 1, 1, 16'h00AA, 1, 1, 16'h50BC, 2'b01, 4'b0000, "ovl_drop10");
      cyc(0, 1, 1, 16'h00B1, 1, 0, 16'h50BC, 2'b01, 4'b0000, "ovl_gap");
      cyc(0, 1, 1, 16'h00B1, 1, 0, 16'h55FB, 2'b01, 4'b1000, "ovl_next_sop");

`ifdef TX_CRC_ERR_INJECT_EN
      // corrupted CRC word: bit 0 inverted on the edge that loads it
      cyc(1, 0, 0, 16'h0, 1, 0, 16'h50BC, 2'b01, 4'b0000, "inj_rst");
      cyc(0, 1, 1, 16'h1234, 1, 0, 16'h55FB, 2'b01, 4'b1000, "inj_sop");
      cyc(0, 1, 1, 16'h1234, 1, 0, 16'h5555, 2'b00, 4'b1000, "inj_pre2");
      cyc(0, 1, 1, 16'h1234, 1, 0, 16'h5555, 2'b00, 4'b1000, "inj_pre3");
      cyc(0, 1, 1, 16'h1234, 1, 0, 16'hD555, 2'b00, 4'b1000, "inj_sof");
      cyc(0, 1, 1, 16'h1234, 1, 1, 16'h1234, 2'b00, 4'b1000, "inj_w1");
      inj = 1'b1;
      cyc(0, 0, 0, 16'h0, 1, 0, 16'(crc_step(32'hFFFFFFFF, 16'h1234)) ^ 16'h0001, 2'b00, 4'b1000, "inj_crc");
      inj = 1'b0;
      cyc(0, 0, 0, 16'h0, 1, 0, 16'hF7FD, 2'b11, 4'b1100, "inj_eop");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
